tdp_ram_port_client: RTL and testbench
======================================

Name: tdp_ram_port_client

Overview:
- Initiator-side front end for one port of our no-change block RAMs. It converts a valid/ready request stream (read or write) into RAM port strobes: address, data, write enable, enable, output-register enable and output reset.
- It tracks the RAM's fixed read latency and returns read data, in order, on a valid/ready response stream.
- A credit-limited response FIFO absorbs downstream backpressure, so read data is never lost even though the RAM output cannot stall.
- One instance sits beside each RAM port that a datapath engine drives.

Parameters:
- RAM_WIDTH, 18, data width; must match the attached RAM.
- ADDR_WIDTH, 10, address width; must match clogb2(RAM_DEPTH-1) of the RAM.
- READ_LATENCY, 2, RAM read latency in cycles. 1 = LOW_LATENCY RAM, 2 = HIGH_PERFORMANCE RAM. Any other value is a configuration error caught at elaboration.
- RSP_DEPTH, 4, number of response FIFO entries. Must be >= READ_LATENCY+2 for one read per cycle with rsp_ready held high.

Ports:
- clk  in  1  single clock; the RAM port is clocked by the same clk.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  RAM_WIDTH  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the read data.
- rsp_rdata  out  RAM_WIDTH  read data.
- ram_en  out  1  to RAM en.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_din  out  RAM_WIDTH  to RAM din.
- ram_regce  out  1  to RAM regce; held 0 when READ_LATENCY=1.
- ram_rst  out  1  to RAM rst; equals ~rst_n.
- ram_dout  in  RAM_WIDTH  from RAM dout.
- outstanding  out  $clog2(RSP_DEPTH+1)  reads accepted but not yet popped.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - req_ready=0 while rst_n=0.
  - rsp_valid=0.
  - outstanding=0.
  - Latency pipe and FIFO pointers cleared.
  - ram_en=0, ram_we=0, ram_regce=0, ram_rst=1.
  - rsp_rdata is don't-care.
- Credit rule:
  - occ is a registered counter: +1 on read accept, -1 on response pop; both in the same cycle leave it unchanged.
  - req_ready = rst_n && (occ < RSP_DEPTH). This applies to writes as well, so req_ready never depends on req_valid or req_we.
  - A pop does not free a credit until the next cycle.
- RAM drive (combinational pass-through of the accepted request):
  - ram_en = req_valid && req_ready.
  - ram_we = req_we && ram_en.
  - ram_addr = req_addr; ram_din = req_wdata.
  - Writes produce no response.
- Read pipeline:
  - Read accepted in cycle T sets pipe bit p1 in cycle T+1.
  - If READ_LATENCY=2: ram_regce = p1 in cycle T+1, and p1 shifts into p2 in cycle T+2.
  - In cycle T+READ_LATENCY the last pipe bit is high and ram_dout is pushed into the FIFO at the end of that cycle.
  - rsp_valid rises in cycle T+READ_LATENCY+1, so read-to-response latency is READ_LATENCY+1 cycles.
- Response FIFO:
  - rsp_valid = fifo not empty; rsp_rdata = head entry.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop is legal, including when empty (the push is visible the next cycle) and when holding RSP_DEPTH-1 entries.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by construction of the credit rule. An assertion flags a push while full.
- Ordering:
  - Responses return strictly in read-issue order.
  - A write followed by a read to the same address returns the new data (the no-change RAM commits writes at the edge).
  - A read never updates on a write cycle, so no read data is lost.
- No-change property:
  - A write in cycle T+1 between a read's issue and its capture does not alter the captured data, because the RAM holds its last read value during writes.
- Reset mid-operation:
  - In-flight reads and FIFO contents are discarded and never presented.
  - After rst_n returns to 1, the first cycle has req_ready=1 and outstanding=0.

Test Plan:
- Write then read, READ_LATENCY=2:
  - Stimulus: cycle 0 write addr 0x003 data 0x155; cycle 1 read addr 0x003; rsp_ready=1.
  - Required: rsp_valid=1 with rsp_rdata=0x155 in cycle 4 only; ram_regce=1 in cycle 2 only.
- Streaming, READ_LATENCY=2, RSP_DEPTH=4:
  - Stimulus: after writing addr 0..7 with data 0x100+i, issue 8 back-to-back reads with rsp_ready=1.
  - Required: req_ready stays 1 throughout; responses 0x100..0x107 on 8 consecutive cycles.
- Backpressure:
  - Stimulus: rsp_ready=0, present 6 reads to addr 0..5.
  - Required: exactly 4 accepted; req_ready=0 from the cycle after the 4th accept; outstanding=4.
  - Then raise rsp_ready: 0x100..0x103 drain in order, req_ready returns, remaining 2 reads complete.
- READ_LATENCY=1 configuration:
  - Stimulus: read addr 0x005 (data 0x105) in cycle 0.
  - Required: rsp_valid=1 in cycle 2; ram_regce never asserted.
- Write during read latency:
  - Stimulus: read addr 2 in cycle 0, write addr 2 with 0x3FF in cycle 1, read addr 2 in cycle 2.
  - Required: responses are 0x102 then 0x3FF.
- Reset mid-operation:
  - Stimulus: 3 reads in flight with rsp_ready=0, then rst_n=0 for 1 cycle.
  - Required: rsp_valid=0 and outstanding=0 during and after reset; no stale response ever appears; ram_rst=1 during reset.

Source files
------------

// File: rtl/tdp_ram_port_client.sv
// Request/response front end for one port of a no-change block RAM.
// Read data returns in order through a response FIFO. Credits are taken per read, so the FIFO cannot overflow.
module tdp_ram_port_client #(
  parameter int RAM_WIDTH    = 18,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [RAM_WIDTH-1:0]             req_wdata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [RAM_WIDTH-1:0]             rsp_rdata,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [RAM_WIDTH-1:0]             ram_din,
  output logic                             ram_regce,
  output logic                             ram_rst,
  input  logic [RAM_WIDTH-1:0]             ram_dout,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   outstanding
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("tdp_ram_port_client: READ_LATENCY must be 1 or 2");
  end

  logic [CW-1:0]           r_occ;
  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [RAM_WIDTH-1:0]    r_mem [RSP_DEPTH];
  logic [READ_LATENCY-1:0] r_pipe;

  logic w_accept;
  logic w_rd_accept;
  logic w_push;
  logic w_pop;
  logic w_empty;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both in-flight reads and FIFO entries. Writes are gated too.
  assign req_ready   = rst_n && (r_occ < DEPTH_C);
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_we;

  assign ram_en   = w_accept;
  assign ram_we   = req_we && w_accept;
  assign ram_addr = req_addr;
  assign ram_din  = req_wdata;
  assign ram_rst  = ~rst_n;

  assign w_push      = r_pipe[READ_LATENCY-1];
  assign w_empty     = (r_cnt == '0);
  assign rsp_valid   = rst_n && !w_empty;
  assign rsp_rdata   = r_mem[r_rptr];
  assign w_pop       = rsp_valid && rsp_ready;
  assign outstanding = rst_n ? r_occ : '0;

  if (READ_LATENCY == 2) begin : g_hp
    always_ff @(posedge clk) begin
      if (!rst_n) r_pipe <= '0;
      else        r_pipe <= {r_pipe[0], w_rd_accept};
    end
    assign ram_regce = rst_n && r_pipe[0];
  end else begin : g_lp
    always_ff @(posedge clk) begin
      if (!rst_n) r_pipe <= '0;
      else        r_pipe <= w_rd_accept;
    end
    assign ram_regce = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_rd_accept, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= ram_dout;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_cnt == DEPTH_C)));

endmodule

// File: tb/tb_tdp_ram_port_client.sv
// Bench for tdp_ram_port_client: drives a no-change RAM model on each port.
// A queue-based model checks the READ_LATENCY=2 instance every cycle, and directed checks pin fixed cycle numbers.
module tb_tdp_ram_port_client;
  localparam int AW = 10;
  localparam int DW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid, req_we, rsp_ready, req_ready, rsp_valid;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;
  logic          ram_en, ram_we, ram_regce, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [2:0]    outstanding;

  logic          b_req_valid, b_req_we, b_rsp_ready, b_req_ready, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
  logic          b_ram_en, b_ram_we, b_ram_regce, b_ram_rst;
  logic [AW-1:0] b_ram_addr;
  logic [DW-1:0] b_ram_din, b_ram_dout;
  logic [2:0]    b_outstanding;

  tdp_ram_port_client #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RSP_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_regce(ram_regce), .ram_rst(ram_rst), .ram_dout(ram_dout), .outstanding(outstanding));

  tdp_ram_port_client #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RSP_DEPTH(4)) u_dut_ll (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_din(b_ram_din), .ram_regce(b_ram_regce), .ram_rst(b_ram_rst), .ram_dout(b_ram_dout),
    .outstanding(b_outstanding));

  // No-change RAM models: the read latch holds its value during write cycles.
  logic [DW-1:0] a_mem [0:1023];
  logic [DW-1:0] b_mem [0:1023];
  logic [DW-1:0] a_lat;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) a_mem[ram_addr] <= ram_din;
      else        a_lat <= a_mem[ram_addr];
    end
    if (ram_rst)        ram_dout <= '0;
    else if (ram_regce) ram_dout <= a_lat;
  end

  always @(posedge clk) begin
    if (b_ram_en) begin
      if (b_ram_we) b_mem[b_ram_addr] <= b_ram_din;
      else          b_ram_dout <= b_mem[b_ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: shadow memory plus an ordered queue of (data, earliest visible cycle).
  logic [DW-1:0] sh [0:1023];
  logic [DW-1:0] q_d [$];
  int unsigned   q_t [$];
  int unsigned   m_occ = 0;
  logic          m_acc_prev = 1'b0;
  int unsigned   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model
    logic e_ready, e_valid, e_en, acc, pop;
    e_ready = rst_n && (m_occ < 4);
    e_valid = rst_n && (q_d.size() > 0) && (q_t[0] <= cyc);
    e_en    = req_valid && e_ready;
    chk("m_req_ready", 32'(req_ready), 32'(e_ready));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(e_valid));
    chk("m_outstanding", 32'(outstanding), rst_n ? m_occ : 32'd0);
    chk("m_ram_en", 32'(ram_en), 32'(e_en));
    chk("m_ram_we", 32'(ram_we), 32'(e_en && req_we));
    chk("m_ram_regce", 32'(ram_regce), 32'(rst_n && m_acc_prev));
    chk("m_ram_rst", 32'(ram_rst), 32'(!rst_n));
    chk("m_ll_regce", 32'(b_ram_regce), 32'd0);
    if (e_en) begin
      chk("m_ram_addr", 32'(ram_addr), 32'(req_addr));
      chk("m_ram_din", 32'(ram_din), 32'(req_wdata));
    end
    if (e_valid) chk("m_rsp_rdata", 32'(rsp_rdata), 32'(q_d[0]));

    acc = e_en;
    pop = e_valid && rsp_ready;
    if (!rst_n) begin
      q_d.delete();
      q_t.delete();
      m_occ = 0;
      m_acc_prev = 1'b0;
    end else begin
      if (pop) begin
        void'(q_d.pop_front());
        void'(q_t.pop_front());
        m_occ--;
      end
      if (acc && req_we) sh[req_addr] = req_wdata;
      else if (acc) begin
        q_d.push_back(sh[req_addr]);
        q_t.push_back(cyc + 3);
        m_occ++;
      end
      m_acc_prev = acc && !req_we;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input int a, input int d);
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(a);
    req_wdata = DW'(d);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  logic [DW-1:0] got [$];
  int idx;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
      sh[i]    = '0;
    end
    b_mem[5] = 18'h105;
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;

    // Reset state, with a request presented throughout
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_outstanding", 32'(outstanding), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_rst", 32'(ram_rst), 32'd1);
    end
    next_cycle();
    rst_n = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    next_cycle();
    idle(2);

    // Write then read
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      drive(1'b1, 1'b1, 3, 'h155);
      else if (k == 1) drive(1'b1, 1'b0, 3, 0);
      else             drive(1'b0, 1'b0, 0, 0);
      @(negedge clk);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'(k == 4));
      chk("t1_regce", 32'(ram_regce), 32'(k == 2));
      if (k == 4) chk("t1_rdata", 32'(rsp_rdata), 32'h155);
      next_cycle();
    end

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, i, 'h100 + i);
      next_cycle();
    end
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(1'b1, 1'b0, k, 0);
      else       drive(1'b0, 1'b0, 0, 0);
      @(negedge clk);
      if (k < 8) chk("t2_req_ready", 32'(req_ready), 32'd1);
      chk("t2_rsp_valid", 32'(rsp_valid), 32'(k >= 3 && k < 11));
      if (k >= 3 && k < 11) chk("t2_rdata", 32'(rsp_rdata), 32'('h100 + k - 3));
      next_cycle();
    end
    idle(2);

    // Backpressure
    rsp_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, idx, 0);
      @(negedge clk);
      if (k >= 4) chk("t3_ready_low", 32'(req_ready), 32'd0);
      if (req_valid && req_ready) idx++;
      next_cycle();
    end
    chk("t3_accepted", 32'(idx), 32'd4);
    chk("t3_outstanding", 32'(outstanding), 32'd4);
    rsp_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 30 && got.size() < 6; k++) begin
      if (idx < 6) drive(1'b1, 1'b0, idx, 0);
      else         drive(1'b0, 1'b0, 0, 0);
      @(negedge clk);
      if (req_valid && req_ready) idx++;
      if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
      next_cycle();
    end
    chk("t3_resp_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk("t3_resp_data", 32'(got[i]), 32'('h100 + i));
    idle(3);

    // Write during read latency
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      drive(1'b1, 1'b0, 2, 0);
      else if (k == 1) drive(1'b1, 1'b1, 2, 'h3FF);
      else if (k == 2) drive(1'b1, 1'b0, 2, 0);
      else             drive(1'b0, 1'b0, 0, 0);
      @(negedge clk);
      chk("t5_rsp_valid", 32'(rsp_valid), 32'(k == 3 || k == 5));
      if (k == 3) chk("t5_rdata_old", 32'(rsp_rdata), 32'h102);
      if (k == 5) chk("t5_rdata_new", 32'(rsp_rdata), 32'h3FF);
      next_cycle();
    end

    // READ_LATENCY=1 instance
    for (int k = 0; k < 6; k++) begin
      b_req_valid = (k == 0);
      b_req_we    = 1'b0;
      b_req_addr  = AW'(5);
      @(negedge clk);
      if (k == 0) chk("ll_req_ready", 32'(b_req_ready), 32'd1);
      chk("ll_rsp_valid", 32'(b_rsp_valid), 32'(k == 2));
      if (k == 2) chk("ll_rdata", 32'(b_rsp_rdata), 32'h105);
      next_cycle();
    end

    // Reset mid-operation
    rsp_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k < 3) drive(1'b1, 1'b0, k, 0);
      else       drive(1'b0, 1'b0, 0, 0);
      rst_n = (k != 4);
      if (k >= 5) rsp_ready = 1'b1;
      @(negedge clk);
      if (k == 3) chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
      if (k == 4) begin
        chk("t6_ram_rst", 32'(ram_rst), 32'd1);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
      end
      if (k >= 4) begin
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_outstanding", 32'(outstanding), 32'd0);
      end
      if (k == 5) chk("t6_ready_back", 32'(req_ready), 32'd1);
      next_cycle();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
